// File: rtl/imm_ext_pkg.sv
// Shared constants for the immediate-extension stage: mode encodings and
// fixed widths of the mode field and the illegal-mode counter.
package imm_ext_pkg;

    localparam int MODE_W   = 3;
    localparam int ERRCNT_W = 8;

    localparam logic [MODE_W-1:0] MODE_ZEXT     = 3'd0;
    localparam logic [MODE_W-1:0] MODE_SEXT     = 3'd1;
    localparam logic [MODE_W-1:0] MODE_UPPER    = 3'd2;
    localparam logic [MODE_W-1:0] MODE_SEXT_SHL = 3'd3;
    localparam logic [MODE_W-1:0] MODE_ZEXT_SHL = 3'd4;

endpackage

// File: rtl/imm_ext_stage_if.sv
// Handshake bundle between decode (master) and the immediate-extension
// stage (slave), including the result side and the error counter.
interface imm_ext_stage_if
    import imm_ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int TAG_W  = 5
) ();

    logic                in_valid;
    logic                in_ready;
    logic [IMM_W-1:0]    in_imm;
    logic [MODE_W-1:0]   in_mode;
    logic [TAG_W-1:0]    in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [DATA_W-1:0]   out_data;
    logic [TAG_W-1:0]    out_tag;
    logic                out_err;
    logic [ERRCNT_W-1:0] err_cnt;

    modport master (
        output in_valid, in_imm, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_err, err_cnt
    );

    modport slave (
        input  in_valid, in_imm, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_err, err_cnt
    );

endinterface

// File: rtl/imm_ext_core.sv
// Combinational immediate extension: {imm, mode} -> {data, err}.
// Illegal modes yield zero data with err set.
module imm_ext_core
    import imm_ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int SHAMT  = 2
) (
    input  logic [IMM_W-1:0]  imm_i,
    input  logic [MODE_W-1:0] mode_i,
    output logic [DATA_W-1:0] data_o,
    output logic              err_o
);

    logic [DATA_W-1:0]        zext_w;
    logic signed [DATA_W-1:0] sext_w;
    logic [DATA_W-1:0]        upper_w;

    assign zext_w  = {{(DATA_W-IMM_W){1'b0}}, imm_i};
    assign sext_w  = signed'({{(DATA_W-IMM_W){imm_i[IMM_W-1]}}, imm_i});
    assign upper_w = {imm_i, {(DATA_W-IMM_W){1'b0}}};

    always_comb begin
        data_o = '0;
        err_o  = 1'b0;
        case (mode_i)
            MODE_ZEXT:     data_o = zext_w;
            MODE_SEXT:     data_o = sext_w;
            MODE_UPPER:    data_o = upper_w;
            MODE_SEXT_SHL: data_o = sext_w << SHAMT;
            MODE_ZEXT_SHL: data_o = zext_w << SHAMT;
            default:       err_o  = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_ext_stage.sv
// Registered immediate-extension stage with an output register O and a skid
// register S so in_ready never depends combinationally on out_ready.
module imm_ext_stage
    import imm_ext_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IMM_W  = 16,
    parameter int SHAMT  = 2,
    parameter int TAG_W  = 5
) (
    input logic           clk,
    input logic           rst_n,
    imm_ext_stage_if.slave bus
);

    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic [DATA_W-1:0]   res_data;
    logic                res_err;

    logic                o_vld_q, o_vld_d, s_vld_q, s_vld_d;
    logic [DATA_W-1:0]   o_data_q, o_data_d, s_data_q, s_data_d;
    logic [TAG_W-1:0]    o_tag_q, o_tag_d, s_tag_q, s_tag_d;
    logic                o_err_q, o_err_d, s_err_q, s_err_d;
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;
    logic                accept, drain;

    imm_ext_core #(.DATA_W(DATA_W), .IMM_W(IMM_W), .SHAMT(SHAMT)) u_core (
        .imm_i  (bus.in_imm),
        .mode_i (bus.in_mode),
        .data_o (res_data),
        .err_o  (res_err)
    );

    assign bus.in_ready = rst_n && !s_vld_q;
    assign accept       = bus.in_valid && bus.in_ready;
    assign drain        = o_vld_q && bus.out_ready;

    // accept implies S empty, so the accept and S->O refill branches never overlap
    always_comb begin
        o_vld_d   = o_vld_q;
        o_data_d  = o_data_q;
        o_tag_d   = o_tag_q;
        o_err_d   = o_err_q;
        s_vld_d   = s_vld_q;
        s_data_d  = s_data_q;
        s_tag_d   = s_tag_q;
        s_err_d   = s_err_q;
        err_cnt_d = err_cnt_q;

        if (accept && (!o_vld_q || bus.out_ready)) begin
            o_vld_d  = 1'b1;
            o_data_d = res_data;
            o_tag_d  = bus.in_tag;
            o_err_d  = res_err;
        end else if (accept) begin
            s_vld_d  = 1'b1;
            s_data_d = res_data;
            s_tag_d  = bus.in_tag;
            s_err_d  = res_err;
        end else if (drain && s_vld_q) begin
            o_data_d = s_data_q;
            o_tag_d  = s_tag_q;
            o_err_d  = s_err_q;
            s_vld_d  = 1'b0;
        end else if (drain) begin
            o_vld_d  = 1'b0;
        end

        if (accept && res_err) begin
            err_cnt_d = sat_inc(err_cnt_q);
        end
    end

    // register stage: O, S and the error counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_vld_q   <= 1'b0;
            o_data_q  <= '0;
            o_tag_q   <= '0;
            o_err_q   <= 1'b0;
            s_vld_q   <= 1'b0;
            s_data_q  <= '0;
            s_tag_q   <= '0;
            s_err_q   <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            o_vld_q   <= o_vld_d;
            o_data_q  <= o_data_d;
            o_tag_q   <= o_tag_d;
            o_err_q   <= o_err_d;
            s_vld_q   <= s_vld_d;
            s_data_q  <= s_data_d;
            s_tag_q   <= s_tag_d;
            s_err_q   <= s_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign bus.out_valid = o_vld_q;
    assign bus.out_data  = o_data_q;
    assign bus.out_tag   = o_tag_q;
    assign bus.out_err   = o_err_q;
    assign bus.err_cnt   = err_cnt_q;

endmodule

// File: doc/imm_ext_stage.md
# imm_ext_stage

Parametrised, pipelined successor to the combinational immediate-extension unit in the decode path. Takes an IMM_W-bit instruction immediate plus an explicit extension mode and produces a DATA_W-bit operand through a one-cycle registered stage with valid/ready handshaking and a skid buffer. Illegal modes are flagged and counted. It sits between the decode stage and the operand-select mux feeding the ALU/branch adder.

## Interface
Parameters:
- DATA_W, 32, output operand width; must satisfy DATA_W > IMM_W.
- IMM_W, 16, immediate field width.
- SHAMT, 2, left-shift amount for the shifted modes (branch/jump word offsets); 0 ≤ SHAMT < DATA_W.
- TAG_W, 5, width of the sideband tag carried alongside each operand (e.g. destination register).

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream has an immediate to extend.
- in_ready  out  1  stage can accept; forced 0 while rst_n low.
- in_imm  in  IMM_W  raw immediate field.
- in_mode  in  3  extension mode (see Operation).
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  out_data/out_tag/out_err hold a result.
- out_ready  in  1  downstream consumes the result this cycle.
- out_data  out  DATA_W  extended operand.
- out_tag  out  TAG_W  tag of that result.
- out_err  out  1  result came from an illegal mode.
- err_cnt  out  8  saturating count of accepted illegal-mode requests.

## Operation
- Modes: 0 ZEXT = zero-extend; 1 SEXT = sign-extend from bit IMM_W-1; 2 UPPER = imm placed in top IMM_W bits, low bits 0; 3 SEXT_SHL = SEXT result << SHAMT, bits shifted past DATA_W-1 dropped; 4 ZEXT_SHL = ZEXT result << SHAMT; 5–7 illegal → data 0, err 1.
- Accept = in_valid && in_ready. Extension is combinational on the input side; the registered result carries {data, tag, err}.
- Two storage slots: output register O and skid register S.
- On accept: if O empty or out_ready this cycle, result loads into O; otherwise into S.
- On out_ready && out_valid with S full: S moves into O, S empties (in_ready is 0 that cycle, so no simultaneous accept).
- in_ready = rst_n && !S_valid (registered source, no combinational path from out_ready).
- err_cnt increments by 1 on each accept with illegal mode; holds at 255.
- Reset (asynchronous, any time, including mid-transfer): O and S invalidated, out_valid 0, out_data 0, out_tag 0, out_err 0, err_cnt 0, in_ready 0 while asserted and 1 the first cycle after release. In-flight results are discarded, not replayed.

## Timing
- Latency: accept in cycle N → out_valid, out_data in cycle N+1 (when O was free).
- Throughput: 1 result/cycle while out_ready stays high.
- Backpressure: out_ready low with O full → one more accept lands in S, in_ready drops the next cycle; at most 2 results buffered.
- Outputs stay stable while out_valid && !out_ready.
- Order is strictly preserved; no result is duplicated or dropped.
- Simultaneous accept and drain with S empty: O is overwritten with the new result in the same edge.

## Structure
- Shared package imm_ext_pkg: mode constants MODE_ZEXT..MODE_ZEXT_SHL, MODE_W = 3, ERRCNT_W = 8.
- Sub-module imm_ext_core: purely combinational {imm, mode} → {data, err}, parametrised by DATA_W/IMM_W/SHAMT; instantiated once ahead of the O/S registers.

## Test plan
DATA_W=32, IMM_W=16, SHAMT=2 unless stated.
- imm 16'hFF00, out_ready=1, modes 0..4 back-to-back → 0x0000FF00, 0xFFFFFF00, 0xFF000000, 0xFFFFFC00, 0x0003FC00 on consecutive cycles, each one cycle after accept, tags in order.
- imm 16'h7FFF mode 1, then mode 3 → 0x00007FFF, 0x0001FFFC.
- out_ready held 0, stream of 4 valid requests tags 1..4 → tags 1,2 accepted, in_ready 0 from the cycle after the second accept; release out_ready → tags 1,2,3,4 emerge in order, none lost.
- Modes 5, 6, 7 accepted, then 300 further illegal requests → out_data 0, out_err 1 each; err_cnt reads 3 then saturates at 255.
- rst_n pulsed low asynchronously with O and S full → out_valid 0 and err_cnt 0 immediately, in_ready 0 during reset, 1 the cycle after release.
- DATA_W=64, IMM_W=12, SHAMT=1: imm 12'h800 mode 3 → 0xFFFFFFFFFFFFF000; mode 2 → 0x8000000000000000.
